xram_arbiter: RTL

XRAM_ARBITER -- requirements
Module: xram_arbiter

---
 rtl/xram_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/xram_arbiter.sv
// Arbitrates one external SRAM between the AVR external-memory bus and a DMA port.
// Each access holds the memory for ACCESS_CYCLES cycles, and at least one IDLE cycle separates two accesses.
module xram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cpu_cs,
  input  logic                  cpu_oe,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_a,
  input  logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_din,
  output logic                  cpu_wait,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [7:0]            dma_wdata,
  output logic [7:0]            dma_rdata,
  output logic                  dma_ack,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_d_out,
  input  logic [7:0]            mem_d_in
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       last_dma_reg, last_dma_next;
  logic       dma_ack_reg;
  logic [7:0] dma_rdata_reg;

  logic cpu_req, dma_req_eff, acc_last;

  assign cpu_req     = cpu_cs & (cpu_oe | cpu_we);
  // A request seen during the ack cycle belongs to the access just finished.
  assign dma_req_eff = dma_req & ~dma_ack_reg;
  assign acc_last    = (state_reg != IDLE) && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      last_dma_reg  <= 1'b1;
      dma_ack_reg   <= 1'b0;
      dma_rdata_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_dma_reg <= last_dma_next;
      dma_ack_reg  <= (state_reg == DMA_ACC) && acc_last;
      if ((state_reg == DMA_ACC) && acc_last && !dma_we)
        dma_rdata_reg <= mem_d_in;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_dma_next = last_dma_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = 4'd0;
        // On a tie, the requester that was not granted last wins.
        if (cpu_req && (!dma_req_eff || last_dma_reg)) begin
          state_next    = CPU_ACC;
          last_dma_next = 1'b0;
        end else if (dma_req_eff) begin
          state_next    = DMA_ACC;
          last_dma_next = 1'b1;
        end
      end
      CPU_ACC, DMA_ACC: begin
        if (acc_last) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_d_out = 8'h00;
    case (state_reg)
      CPU_ACC: begin
        mem_cs    = 1'b1;
        mem_we    = cpu_we;
        mem_a     = cpu_a;
        mem_d_out = cpu_dout;
      end
      DMA_ACC: begin
        mem_cs    = 1'b1;
        mem_we    = dma_we;
        mem_a     = dma_addr;
        mem_d_out = dma_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_wait  = cpu_req & ~((state_reg == CPU_ACC) && acc_last);
  assign cpu_din   = ((state_reg == CPU_ACC) && acc_last) ? mem_d_in : 8'h00;
  assign dma_ack   = dma_ack_reg;
  assign dma_rdata = dma_rdata_reg;

endmodule
